itch_msg_parser: RTL and testbench

- Byte-serial market-feed framer/decoder directly upstream of order_book.
- Assembles fixed 16-byte wire frames into parsed_msg_t, validates them and buffers them in an internal show-ahead FIFO.
- Exposes the FIFO to order_book through read_en/empty/parsed_message.

---
 rtl/itch_msg_parser_pkg.sv | 50 +++++
 rtl/parsed_msg_fifo.sv | 59 +++++
 rtl/itch_msg_parser.sv | 161 ++++++++++++++++
 tb/tb_itch_msg_parser.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_msg_parser_pkg.sv
// parser_defs: shared types and wire constants for the ITCH frame parser
// and for any block that consumes its parsed messages (e.g. order_book).
//   msg_type_t    - decoded message kind
//   order_side_t  - bid / ask
//   parsed_msg_t  - one decoded 16-byte wire frame
//   parser_state_t- framer FSM encoding
package parser_defs;

  typedef enum logic [1:0] {
    MSG_ADD     = 2'd0,
    MSG_CANCEL  = 2'd1,
    MSG_EXECUTE = 2'd2,
    MSG_REPLACE = 2'd3
  } msg_type_t;

  typedef enum logic {
    ORDER_SIDE_BID = 1'b0,
    ORDER_SIDE_ASK = 1'b1
  } order_side_t;

  typedef struct packed {
    msg_type_t   msg_type;
    logic [7:0]  symbol_id;
    logic [31:0] order_id;
    order_side_t side;
    logic [31:0] price;
    logic [31:0] quantity;
    logic [7:0]  trailer;
  } parsed_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DROP    = 2'd3
  } parser_state_t;

  localparam int MSG_W      = $bits(parsed_msg_t);
  localparam int FRAME_LEN  = 16;
  localparam int FRAME_BITS = FRAME_LEN * 8;

  localparam logic [7:0] TRAILER      = 8'hFF;
  localparam logic [7:0] CODE_ADD     = 8'h41;  // 'A'
  localparam logic [7:0] CODE_CANCEL  = 8'h58;  // 'X'
  localparam logic [7:0] CODE_EXECUTE = 8'h45;  // 'E'
  localparam logic [7:0] CODE_REPLACE = 8'h55;  // 'U'
  localparam logic [7:0] CODE_BID     = 8'h42;  // 'B'
  localparam logic [7:0] CODE_ASK     = 8'h53;  // 'S'

endpackage

// File: rtl/parsed_msg_fifo.sv
// parsed_msg_fifo: show-ahead FIFO of parsed_msg_t words.
//   clk, reset(async, active-low)
//   push/push_data : write one entry
//   pop            : drop head (ignored while empty)
//   head           : mem[rd_ptr], meaningful only when !empty
//   full/empty/count
module parsed_msg_fifo
  import parser_defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [MSG_W-1:0]         push_data,
  input  logic                     pop,
  output logic [MSG_W-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [MSG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is only legal when a pop frees the slot
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/itch_msg_parser.sv
// itch_msg_parser: byte-serial framer/decoder for 16-byte market-feed frames,
// buffering decoded messages in a show-ahead FIFO read by order_book.
//   clk, reset(async, active-low)
//   in_valid/in_sof/in_data/in_ready : byte stream, accepted on valid&&ready
//   read_en/empty/parsed_message     : FIFO read side
//   frame_err                        : one-cycle pulse per dropped frame
//   frames_ok/frames_dropped         : saturating stats, only with PARSER_STATS_EN
//
// state   | meaning
// IDLE    | waiting for an in_sof byte; stalls while the FIFO cannot take a frame
// COLLECT | shifting bytes 1..15 into the frame register
// CHECK   | one cycle: validate type/side/trailer, queue push or flag error
// DROP    | reserved encoding, falls back to IDLE
module itch_msg_parser
  import parser_defs::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             read_en,
  output logic             empty,
  output logic [MSG_W-1:0] parsed_message,
  output logic             frame_err
`ifdef PARSER_STATS_EN
  ,
  output logic [15:0]      frames_ok,
  output logic [15:0]      frames_dropped
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  parser_state_t         state, state_nxt;
  logic [3:0]            byte_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  accept;
  logic                  chk_push;
  logic                  err;
  logic                  push_q;
  parsed_msg_t           msg, msg_q;
  logic                  type_ok, side_ok, frame_ok;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_busy;

  assign accept = in_valid && in_ready;

  // The decoded message is pushed one cycle after CHECK, so a new frame may
  // only start when the FIFO has room for that in-flight entry too.
  assign fifo_busy = fifo_full || (push_q && fifo_count == ALMOST_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    chk_push  = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !fifo_busy;
        if (in_valid && !fifo_busy && in_sof) state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (in_valid) begin
          if (in_sof)                     err       = 1'b1;
          else if (byte_cnt == LAST_IDX)  state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        in_ready  = 1'b0;
        state_nxt = ST_IDLE;
        if (frame_ok) chk_push = 1'b1;
        else          err      = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte i of the frame ends up at frame[127-8i -: 8] after 16 shifts.
  always_comb begin
    msg          = '0;
    type_ok      = 1'b1;
    side_ok      = 1'b1;
    case (frame[127:120])
      CODE_ADD:     msg.msg_type = MSG_ADD;
      CODE_CANCEL:  msg.msg_type = MSG_CANCEL;
      CODE_EXECUTE: msg.msg_type = MSG_EXECUTE;
      CODE_REPLACE: msg.msg_type = MSG_REPLACE;
      default:      type_ok      = 1'b0;
    endcase
    case (frame[79:72])
      CODE_BID: msg.side = ORDER_SIDE_BID;
      CODE_ASK: msg.side = ORDER_SIDE_ASK;
      default:  side_ok  = 1'b0;
    endcase
    msg.symbol_id = frame[119:112];
    msg.order_id  = frame[111:80];
    msg.price     = frame[71:40];
    msg.quantity  = frame[39:8];
    msg.trailer   = frame[7:0];
  end

  assign frame_ok = type_ok && side_ok && (frame[7:0] == TRAILER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= '0;
      frame     <= '0;
      push_q    <= 1'b0;
      msg_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      push_q    <= chk_push;
      if (chk_push) msg_q <= msg;
      if (accept && in_sof && (state == ST_IDLE || state == ST_COLLECT)) begin
        frame    <= {{(FRAME_BITS-8){1'b0}}, in_data};
        byte_cnt <= 4'd1;
      end else if (accept && state == ST_COLLECT) begin
        frame    <= {frame[FRAME_BITS-9:0], in_data};
        byte_cnt <= byte_cnt + 4'd1;
      end
    end
  end

  parsed_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (msg_q),
    .pop       (read_en),
    .head      (parsed_message),
    .full      (fifo_full),
    .empty     (empty),
    .count     (fifo_count)
  );

`ifdef PARSER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      if (push_q && frames_ok != 16'hFFFF)   frames_ok      <= frames_ok + 16'd1;
      if (err && frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_itch_msg_parser.sv
`timescale 1ns/1ps
module tb_itch_msg_parser;
  import parser_defs::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic read_en = 1'b0;
  logic in_ready, empty, frame_err;
  logic [MSG_W-1:0] parsed_message;
`ifdef PARSER_STATS_EN
  logic [15:0] frames_ok, frames_dropped;
`endif

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  bit rd_mode = 1'b0;
  bit rd_force = 1'b0;

  always #5 clk = ~clk;

  itch_msg_parser #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .read_en        (read_en),
    .empty          (empty),
    .parsed_message (parsed_message),
    .frame_err      (frame_err)
`ifdef PARSER_STATS_EN
    ,
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame in progress as a byte list; a complete frame is judged one cycle
  // later and, if good, lands in the message queue one cycle after that.
  logic [7:0]  m_frame[$];
  bit          m_collect, m_check, m_pending, m_err;
  parsed_msg_t m_pend_msg;
  parsed_msg_t m_fifo[$];
  int          m_ok_cnt, m_drop_cnt;
  bit          mdl_acc, mdl_ok;
  parsed_msg_t mdl_msg;

  function automatic bit decode(input logic [7:0] b[$], output parsed_msg_t m);
    bit ok = 1'b1;
    m = '0;
    case (b[0])
      8'h41:   m.msg_type = MSG_ADD;
      8'h58:   m.msg_type = MSG_CANCEL;
      8'h45:   m.msg_type = MSG_EXECUTE;
      8'h55:   m.msg_type = MSG_REPLACE;
      default: ok = 1'b0;
    endcase
    case (b[6])
      8'h42:   m.side = ORDER_SIDE_BID;
      8'h53:   m.side = ORDER_SIDE_ASK;
      default: ok = 1'b0;
    endcase
    m.symbol_id = b[1];
    m.order_id  = {b[2], b[3], b[4], b[5]};
    m.price     = {b[7], b[8], b[9], b[10]};
    m.quantity  = {b[11], b[12], b[13], b[14]};
    m.trailer   = b[15];
    if (b[15] != 8'hFF) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit model_ready();
    int occupancy = m_fifo.size() + (m_pending ? 1 : 0);
    return !m_check && !(!m_collect && occupancy >= DEPTH);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_frame.delete();
      m_fifo.delete();
      m_collect  = 1'b0;
      m_check    = 1'b0;
      m_pending  = 1'b0;
      m_err      = 1'b0;
      m_ok_cnt   = 0;
      m_drop_cnt = 0;
    end else begin
      mdl_acc = in_valid && model_ready();
      m_err = 1'b0;
      if (read_en && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (m_pending) begin
        m_fifo.push_back(m_pend_msg);
        m_pending = 1'b0;
        if (m_ok_cnt < 16'hFFFF) m_ok_cnt++;
      end
      if (m_check) begin
        m_check = 1'b0;
        mdl_ok = decode(m_frame, mdl_msg);
        if (mdl_ok) begin
          m_pending  = 1'b1;
          m_pend_msg = mdl_msg;
        end else m_err = 1'b1;
      end else if (mdl_acc) begin
        if (in_sof) begin
          if (m_collect) m_err = 1'b1;
          m_frame.delete();
          m_frame.push_back(in_data);
          m_collect = 1'b1;
        end else if (m_collect) begin
          m_frame.push_back(in_data);
          if (m_frame.size() == FRAME_LEN) begin
            m_collect = 1'b0;
            m_check   = 1'b1;
          end
        end
      end
      if (m_err && m_drop_cnt < 16'hFFFF) m_drop_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("in_ready", in_ready, model_ready());
    check("empty", empty, m_fifo.size() == 0);
    check("frame_err", frame_err, m_err);
    if (m_fifo.size() > 0) check("parsed_message", parsed_message, m_fifo[0]);
`ifdef PARSER_STATS_EN
    check("frames_ok", frames_ok, m_ok_cnt);
    check("frames_dropped", frames_dropped, m_drop_cnt);
`endif
    if (frame_err) err_pulses++;
  end

  always @(posedge clk) begin
    #2;
    read_en = rd_mode ? ($urandom_range(0, 2) == 0) : rd_force;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic sof, input logic [7:0] d);
    int n = 0;
    logic rdy;
    in_valid = 1'b1; in_sof = sof; in_data = d;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stuck low at %0t", $time);
        break;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  function automatic void make_frame(output logic [7:0] b[16], input logic [7:0] typ,
      input logic [7:0] sym, input logic [31:0] oid, input logic [7:0] side,
      input logic [31:0] price, input logic [31:0] qty, input logic [7:0] trl);
    b[0] = typ; b[1] = sym;
    for (int i = 0; i < 4; i++) begin
      b[2+i]  = oid[31-8*i -: 8];
      b[7+i]  = price[31-8*i -: 8];
      b[11+i] = qty[31-8*i -: 8];
    end
    b[6] = side; b[15] = trl;
  endfunction

  task automatic send_frame(input logic [7:0] b[16], input int gap);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      send_byte(i == 0, b[i]);
    end
  endtask

  task automatic pop_one();
    rd_force = 1'b1;
    @(posedge clk); #1;
    rd_force = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rd_mode = 1'b1;
    while (!(empty && m_fifo.size() == 0 && !m_check && !m_pending && !m_collect) && n < 300) begin
      idle(1); n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL drain_timeout: empty=%0b model_size=%0d", empty, m_fifo.size());
    end
    rd_mode = 1'b0;
    idle(2);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  fb[16];
  parsed_msg_t exp_msg, got_msg;
  int          e0, r;

  initial begin
    #2;
    check("rst_empty", empty, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parsed_message", parsed_message, '0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // 1: single valid frame, latency and decoded fields
    make_frame(fb, 8'h41, 8'h01, 32'h11111111, 8'h42, 32'h000003E8, 32'h0000000A, 8'hFF);
    send_frame(fb, 0);
    @(negedge clk); check("lat_check_cycle_empty", empty, 1'b1);
    @(negedge clk); check("lat_plus1_empty", empty, 1'b1);
    @(negedge clk); check("lat_plus2_empty", empty, 1'b0);
    exp_msg = '0;
    exp_msg.msg_type  = MSG_ADD;     exp_msg.symbol_id = 8'h01;
    exp_msg.order_id  = 32'h11111111; exp_msg.side     = ORDER_SIDE_BID;
    exp_msg.price     = 32'd1000;    exp_msg.quantity  = 32'd10;
    exp_msg.trailer   = 8'hFF;
    check("first_msg", parsed_message, exp_msg);
    @(posedge clk); #1; pop_one();
    @(negedge clk); check("after_pop_empty", empty, 1'b1);
    @(posedge clk); #1;

    // 2: bad trailer, then a good frame
    e0 = err_pulses;
    make_frame(fb, 8'h58, 8'h02, 32'h22, 8'h53, 32'd5, 32'd6, 8'h00);
    send_frame(fb, 1);
    idle(4);
    check("bad_trailer_err_pulses", err_pulses - e0, 1);
    check("bad_trailer_empty", empty, 1'b1);
    make_frame(fb, 8'h45, 8'h03, 32'h33, 8'h53, 32'd7, 32'd8, 8'hFF);
    send_frame(fb, 1);
    idle(3);
    got_msg = parsed_message;
    check("after_bad_order_id", got_msg.order_id, 32'h33);
    drain();

    // 3: junk bytes in IDLE, then in_sof again at byte 7
    send_byte(1'b0, 8'h41); send_byte(1'b0, 8'h99);
    e0 = err_pulses;
    make_frame(fb, 8'h55, 8'h04, 32'h44, 8'h42, 32'd9, 32'd1, 8'hFF);
    for (int i = 0; i < 7; i++) send_byte(i == 0, fb[i]);
    make_frame(fb, 8'h55, 8'h05, 32'hA5A50007, 8'h53, 32'd11, 32'd12, 8'hFF);
    send_frame(fb, 0);
    idle(3);
    check("restart_err_pulses", err_pulses - e0, 1);
    got_msg = parsed_message;
    check("restart_order_id", got_msg.order_id, 32'hA5A50007);
    drain();

    // 4: nine frames into a depth-8 FIFO
    for (int k = 1; k <= 8; k++) begin
      make_frame(fb, 8'h41, 8'h10, 32'(k), 8'h42, 32'd100, 32'd1, 8'hFF);
      send_frame(fb, 0);
    end
    idle(4);
    check("full_in_ready_low", in_ready, 1'b0);
    pop_one();
    make_frame(fb, 8'h41, 8'h10, 32'd9, 8'h42, 32'd100, 32'd1, 8'hFF);
    send_frame(fb, 0);
    idle(3);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      got_msg = parsed_message;
      check("order_preserved", got_msg.order_id, 32'(k));
      @(posedge clk); #1; pop_one();
    end
    @(negedge clk); check("order_drained_empty", empty, 1'b1);
    @(posedge clk); #1;

    // 5: pop coincident with push while holding one entry; pop while empty
    make_frame(fb, 8'h41, 8'h20, 32'd100, 8'h42, 32'd1, 32'd1, 8'hFF);
    send_frame(fb, 0);
    idle(3);
    make_frame(fb, 8'h58, 8'h21, 32'd200, 8'h53, 32'd2, 32'd2, 8'hFF);
    send_frame(fb, 0);
    @(posedge clk); #1; rd_force = 1'b1;
    @(posedge clk); #1; rd_force = 1'b0;
    @(negedge clk);
    got_msg = parsed_message;
    check("coincident_head", got_msg.order_id, 32'd200);
    check("coincident_not_empty", empty, 1'b0);
    @(posedge clk); #1; pop_one();
    pop_one();
    @(negedge clk); check("pop_while_empty", empty, 1'b1);
    @(posedge clk); #1;

    // 6: randomized traffic with random corruption and random reads
    rd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      make_frame(fb, 8'h41 , 8'($urandom), $urandom, 8'h42, $urandom, $urandom, 8'hFF);
      case ($urandom_range(0, 3))
        0: fb[0] = 8'h58;
        1: fb[0] = 8'h45;
        2: fb[0] = 8'h55;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) fb[6] = 8'h53;
      r = $urandom_range(0, 9);
      if (r == 0) fb[0] = 8'h30 + 8'($urandom_range(0, 9));
      if (r == 1) fb[6] = 8'h00;
      if (r == 2) fb[15] = 8'($urandom_range(0, 254));
      if (r == 3) begin
        send_byte(1'b1, 8'h41);
        repeat ($urandom_range(0, 13)) send_byte(1'b0, 8'($urandom));
      end
      if (r == 4) send_byte(1'b0, 8'($urandom));
      send_frame(fb, 2);
    end
    drain();

    // 7: reset mid-frame with three messages buffered
    for (int k = 0; k < 3; k++) begin
      make_frame(fb, 8'h45, 8'h30, 32'(300 + k), 8'h53, 32'd3, 32'd3, 8'hFF);
      send_frame(fb, 0);
    end
    idle(3);
    check("three_buffered_not_empty", empty, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(i == 0, fb[i]);
    #2 reset = 1'b0;
    #1;
    check("midreset_empty", empty, 1'b1);
    check("midreset_in_ready", in_ready, 1'b1);
`ifdef PARSER_STATS_EN
    check("midreset_frames_ok", frames_ok, 16'd0);
    check("midreset_frames_dropped", frames_dropped, 16'd0);
`endif
    idle(2);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    make_frame(fb, 8'h55, 8'h31, 32'd400, 8'h42, 32'd4, 32'd4, 8'hFF);
    send_frame(fb, 0);
    idle(3);
    got_msg = parsed_message;
    check("post_reset_order_id", got_msg.order_id, 32'd400);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
